// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares a single byte-wide UART transmitter between four requesters.
//   A round-robin search picks one pending byte, registers it onto uart_din,
//   and pulses uart_wr_en together with the winner's req_ready bit for one
//   cycle. The FSM then follows the transmitter's busy flag through a full
//   high/low handshake before it arbitrates again. No time-out is applied
//   while waiting on the transmitter.
//
// Optional feature (macro UART_ARB_LOCK_EN):
//   When defined, a granted byte whose req_last bit is 0 locks the arbiter
//   to that requester until its req_last=1 byte is granted. When undefined,
//   req_last is ignored and no lock state is built.
//
// Ports:
//   clk_50m       in   1   system clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   req_valid     in   4   requester i has a byte pending
//   req_data      in  32   byte of requester i on bits [8i+7:8i]
//   req_last      in   4   byte of requester i ends its packet (lock mode)
//   req_ready     out  4   one-cycle pulse, byte of requester i accepted
//   uart_din      out  8   byte to the transmitter
//   uart_wr_en    out  1   one-cycle write strobe to the transmitter
//   uart_tx_busy  in   1   transmitter busy flag
//   grant         out  2   index of the most recently granted requester
//   busy          out  1   high whenever the FSM is not in IDLE
//
// States:
//   IDLE    | waiting for an eligible request with the transmitter idle
//   ISSUE   | uart_wr_en and req_ready[grant] asserted for this one cycle
//   WAIT_HI | waiting for the transmitter to report busy
//   WAIT_LO | waiting for the transmitter to finish (busy low again)
// ----------------------------------------------------------------------------
module uart_tx_arbiter (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  uart_din,
    output logic        uart_wr_en,
    input  logic        uart_tx_busy,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;

    logic [3:0] w_eligible;
    logic       w_found;
    logic [1:0] w_sel;
    logic [7:0] w_sel_byte;

`ifdef UART_ARB_LOCK_EN
    logic       r_lock;
    logic [1:0] r_lock_idx;

    // While locked, mask every requester except the lock owner so an idle
    // owner stalls the arbiter instead of letting someone else in.
    always_comb begin
        w_eligible = req_valid;
        if (r_lock) begin
            w_eligible = req_valid & (4'b0001 << r_lock_idx);
        end
    end
`else
    // req_last has no function without the lock feature.
    logic w_unused_last;
    assign w_unused_last = ^req_last;

    always_comb begin
        w_eligible = req_valid;
    end
`endif

    // Round-robin search: start one past the last winner, wrap around, and
    // consider the last winner itself only as the final candidate.
    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_sel   = r_ptr;
        idx     = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            idx = r_ptr + k[1:0];
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    assign w_sel_byte = req_data[{w_sel, 3'b000} +: 8];

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd3;
            uart_din   <= 8'h00;
            uart_wr_en <= 1'b0;
            req_ready  <= 4'b0000;
            grant      <= 2'd0;
            busy       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            r_lock     <= 1'b0;
            r_lock_idx <= 2'd0;
`endif
        end else begin
            // Strobes are single-cycle: only the IDLE grant path raises them.
            uart_wr_en <= 1'b0;
            req_ready  <= 4'b0000;

            case (r_state)
                S_IDLE: begin
                    if (w_found && !uart_tx_busy) begin
                        uart_din   <= w_sel_byte;
                        grant      <= w_sel;
                        r_ptr      <= w_sel;
                        uart_wr_en <= 1'b1;
                        req_ready  <= 4'b0001 << w_sel;
                        busy       <= 1'b1;
                        r_state    <= S_ISSUE;
`ifdef UART_ARB_LOCK_EN
                        // Same expression both takes and releases the lock:
                        // the owner's last byte clears it.
                        r_lock     <= ~req_last[w_sel];
                        r_lock_idx <= w_sel;
`endif
                    end
                end

                // The transfer is committed once here; req_valid is not
                // looked at again.
                S_ISSUE: begin
                    r_state <= S_WAIT_HI;
                end

                S_WAIT_HI: begin
                    if (uart_tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end

                S_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk_50m;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  uart_din;
    logic        uart_wr_en;
    logic        uart_tx_busy;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy),
        .grant        (grant),
        .busy         (busy)
    );

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a write strobe; returns the number of negedges taken.
    task automatic wait_issue(input int budget, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_50m);
            cycles++;
            if (uart_wr_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("issue_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic grant_chk(input string tag, input logic [1:0] eg, input logic [7:0] ed, output int cycles);
        wait_issue(20, cycles);
        chk({tag, "_grant"}, {30'd0, grant}, {30'd0, eg});
        chk({tag, "_din"}, {24'd0, uart_din}, {24'd0, ed});
        chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, 4'b0001 << eg});
    endtask

    // Called in the ISSUE cycle: emulate the transmitter for three cycles.
    task automatic finish_tx(input string tag);
        uart_tx_busy = 1'b1;
        repeat (3) begin
            @(negedge clk_50m);
            chk({tag, "_wr_while_busy"}, {31'd0, uart_wr_en}, 32'd0);
            chk({tag, "_ready_after"}, {28'd0, req_ready}, 32'd0);
        end
        uart_tx_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);
    endtask

    initial begin
        int         cyc;
        int         cnt2;
        logic [1:0] exp_g [5];
        logic [7:0] exp_d [5];

        rst          = 1'b1;
        req_valid    = 4'b0000;
        req_data     = 32'h0;
        req_last     = 4'b0000;
        uart_tx_busy = 1'b0;

        // Reset values
        #12;
        chk("rst_wr_en", {31'd0, uart_wr_en}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_din", {24'd0, uart_din}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);

        // Scenario 1: single request, next-cycle strobe
        req_valid = 4'b0001;
        req_data  = 32'h0000_0041;
        @(negedge clk_50m);
        chk("s1_wr_en", {31'd0, uart_wr_en}, 32'd1);
        chk("s1_din", {24'd0, uart_din}, 32'h41);
        chk("s1_ready", {28'd0, req_ready}, 32'b0001);
        chk("s1_grant", {30'd0, grant}, 32'd0);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        uart_tx_busy = 1'b1;
        @(negedge clk_50m);
        chk("s1_pulse_wr", {31'd0, uart_wr_en}, 32'd0);
        chk("s1_pulse_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk_50m);
        uart_tx_busy = 1'b0;
        repeat (2) @(negedge clk_50m);
        chk("s1_idle_busy", {31'd0, busy}, 32'd0);

        // Scenario 2: all four requesting, 4 bytes each, round-robin order
        do_reset();
        req_data  = 32'hD3C2_B1A0;
        req_valid = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] g;
            g = i[1:0];
            grant_chk("s2", g, 8'hA0 + 8'h11 * {6'd0, g}, cyc);
            if (i == 0) chk("s2_first_latency", cyc, 1);
            else        chk("s2_spacing", cyc, 2);
            finish_tx("s2");
        end
        req_valid = 4'b0000;
        repeat (2) @(negedge clk_50m);

        // Scenario 3: transmitter busy in IDLE blocks the grant
        uart_tx_busy = 1'b1;
        req_valid    = 4'b0100;
        req_data     = 32'h0077_0000;
        repeat (5) begin
            @(negedge clk_50m);
            chk("s3_hold_wr", {31'd0, uart_wr_en}, 32'd0);
            chk("s3_hold_ready", {28'd0, req_ready}, 32'd0);
            chk("s3_hold_busy", {31'd0, busy}, 32'd0);
        end
        uart_tx_busy = 1'b0;
        @(negedge clk_50m);
        chk("s3_wr_en", {31'd0, uart_wr_en}, 32'd1);
        chk("s3_grant", {30'd0, grant}, 32'd2);
        chk("s3_din", {24'd0, uart_din}, 32'h77);
        finish_tx("s3");
        req_valid = 4'b0000;
        repeat (2) @(negedge clk_50m);

        // Scenario 4: reset in WAIT_LO while the transmitter stays busy
        req_valid = 4'b0010;
        req_data  = 32'h0000_6600;
        grant_chk("s4a", 2'd1, 8'h66, cyc);
        req_valid    = 4'b0000;
        uart_tx_busy = 1'b1;
        repeat (2) @(negedge clk_50m);
        chk("s4_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("s4_rst_wr", {31'd0, uart_wr_en}, 32'd0);
        chk("s4_rst_ready", {28'd0, req_ready}, 32'd0);
        chk("s4_rst_din", {24'd0, uart_din}, 32'd0);
        chk("s4_rst_grant", {30'd0, grant}, 32'd0);
        chk("s4_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_50m);
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        repeat (4) begin
            @(negedge clk_50m);
            chk("s4_post_rst_wr", {31'd0, uart_wr_en}, 32'd0);
        end
        uart_tx_busy = 1'b0;
        @(negedge clk_50m);
        chk("s4_wr_en", {31'd0, uart_wr_en}, 32'd1);
        chk("s4_grant_ptr3", {30'd0, grant}, 32'd0);
        chk("s4_din", {24'd0, uart_din}, 32'h11);
        finish_tx("s4");
        req_valid = 4'b0000;
        repeat (2) @(negedge clk_50m);

        // Scenario 5: packet lock (ptr moved to 1 first so requester 2 leads)
        req_valid = 4'b0010;
        req_data  = 32'h0000_5500;
        grant_chk("s5pre", 2'd1, 8'h55, cyc);
        finish_tx("s5pre");
        req_valid = 4'b0000;
        repeat (2) @(negedge clk_50m);
`ifdef UART_ARB_LOCK_EN
        exp_g = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'h30, 8'h30};
`else
        exp_g = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        exp_d = '{8'hA0, 8'h30, 8'hA1, 8'h30, 8'hA2};
`endif
        cnt2      = 0;
        req_data  = 32'h00A0_0030;
        req_last  = 4'b0000;
        req_valid = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            grant_chk("s5", exp_g[i], exp_d[i], cyc);
            if (exp_g[i] == 2'd2) begin
                cnt2++;
                req_data[23:16] = 8'hA0 + cnt2[7:0];
                req_last[2]     = (cnt2 == 2);
                if (cnt2 == 3) req_valid[2] = 1'b0;
            end
            finish_tx("s5");
        end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        repeat (2) @(negedge clk_50m);

        // Scenario 6: req_valid drops during ISSUE
        req_valid = 4'b1000;
        req_data  = 32'h5A00_0000;
        wait_issue(20, cyc);
        req_valid = 4'b0000;
        chk("s6_din", {24'd0, uart_din}, 32'h5A);
        chk("s6_ready", {28'd0, req_ready}, 32'b1000);
        chk("s6_grant", {30'd0, grant}, 32'd3);
        finish_tx("s6");
        repeat (3) begin
            @(negedge clk_50m);
            chk("s6_no_second_wr", {31'd0, uart_wr_en}, 32'd0);
            chk("s6_no_second_ready", {28'd0, req_ready}, 32'd0);
        end
        chk("s6_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
  clk_50m  in  1  system clock; all state updates on its rising edge.
  rst  in  1  asynchronous, active-high reset.
REQ-002 The block SHALL have these requester ports:
  req_valid  in  4  requester i has a byte pending.
  req_data  in  32  byte of requester i on bits [8i+7:8i].
  req_last  in  4  byte of requester i ends its packet; used only when UART_ARB_LOCK_EN is defined.
  req_ready  out  4  one-cycle pulse: byte of requester i accepted.
REQ-003 The block SHALL have these transmitter and status ports:
  uart_din  out  8  byte to the UART transmitter.
  uart_wr_en  out  1  one-cycle write strobe to the transmitter.
  uart_tx_busy  in  1  transmitter busy flag.
  grant  out  2  index of the most recently granted requester.
  busy  out  1  high whenever the state is not IDLE.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-005 In IDLE, when any eligible req_valid bit is 1 and uart_tx_busy is 0, the block SHALL select one requester, register its req_data byte into uart_din and its index into grant, and go to ISSUE.
REQ-006 Selection SHALL be round-robin: the search starts at index (ptr+1) mod 4 and ascends with wrap-around, and ptr is updated to the selected index.
REQ-007 In ISSUE, uart_wr_en and req_ready[grant] SHALL both be 1 for exactly one cycle, and the FSM SHALL go to WAIT_HI unconditionally.
REQ-008 Once ISSUE is entered, the transfer SHALL NOT be cancelled, including when req_valid drops during ISSUE.
REQ-009 In WAIT_HI, the FSM SHALL stay until uart_tx_busy is 1, then go to WAIT_LO; it SHALL NOT time out.
REQ-010 In WAIT_LO, the FSM SHALL stay until uart_tx_busy is 0, then go to IDLE.
REQ-011 Latency: when req_valid is sampled in IDLE with the transmitter idle, uart_wr_en SHALL be high on the next cycle; the minimum spacing between uart_wr_en pulses SHALL be 4 cycles.
REQ-012 uart_din and grant SHALL hold their values from one capture until the next capture.
REQ-013 Outside ISSUE, req_ready and uart_wr_en SHALL both be 0; req_ready SHALL be one-hot or zero.
REQ-014 A requester SHALL hold req_data stable while req_valid is 1 and it has not yet received req_ready; the byte is captured at the IDLE-to-ISSUE transition.
REQ-015 If uart_tx_busy is 1 in IDLE, the block SHALL not grant, and req_ready SHALL stay 0.

Reset
REQ-016 When rst is asserted, the block SHALL immediately force: state IDLE, uart_wr_en 0, req_ready 0, uart_din 8'h00, grant 2'd0, busy 0, ptr 3 (so requester 0 has first priority), and lock cleared.
REQ-017 Reset asserted mid-transfer SHALL NOT abort a transmission already in progress in the transmitter.
REQ-018 After reset is released, the block SHALL wait in IDLE until uart_tx_busy is 0 before granting.

Configuration
REQ-019 With UART_ARB_LOCK_EN defined, granting a byte whose req_last is 0 SHALL lock the arbiter to that requester.
REQ-020 While locked, only the locked requester SHALL be eligible; if its req_valid is 0, the block SHALL wait in IDLE and SHALL NOT grant any other requester.
REQ-021 The lock SHALL be released when the locked requester's byte with req_last 1 is granted, and ptr SHALL then update normally.
REQ-022 Without UART_ARB_LOCK_EN, req_last SHALL be ignored, no lock state SHALL exist, and every byte SHALL be arbitrated independently.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - After reset, req_valid=4'b0001 with byte 8'h41 and transmitter idle -> next cycle uart_wr_en=1, uart_din=8'h41, req_ready=4'b0001, grant=0.
  - req_valid=4'b1111 held for 4 bytes each -> grants in order 0,1,2,3; no uart_wr_en while uart_tx_busy=1.
  - uart_tx_busy held 1 in IDLE with req_valid=4'b0100 -> no grant; grant occurs 1 cycle after uart_tx_busy falls.
  - rst asserted in WAIT_LO -> outputs zero, ptr 3; after release with uart_tx_busy still 1 -> no grant until it falls.
  - Lock mode, requester 2 sends 3 bytes (req_last 0,0,1) while requester 0 is valid -> 2,2,2 then 0; with the macro undefined -> 2,0,2,0,2.
  - req_valid drops during ISSUE -> byte still sent, exactly one req_ready pulse.
